// File: rtl/spi_mem_pkg.sv
// Shared types and defaults for the SPI memory sequencer and its bit counter.
package spi_mem_pkg;

    localparam int   ADDR_W_DEF = 7;
    localparam int   DATA_W_DEF = 8;
    localparam int   RW_BIT     = 0;
    localparam logic CMD_READ   = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CMD       = 4'd1,
        ST_DECODE    = 4'd2,
        ST_RD_FETCH  = 4'd3,
        ST_RD_LOAD   = 4'd4,
        ST_RD_SHIFT  = 4'd5,
        ST_RD_NEXT   = 4'd6,
        ST_WR_SHIFT  = 4'd7,
        ST_WR_COMMIT = 4'd8,
        ST_DONE      = 4'd9
    } state_e;

    // States in which SCLK rising edges advance the bit counter.
    function automatic logic is_count_state(input state_e st);
        return (st == ST_CMD) || (st == ST_WR_SHIFT) || (st == ST_RD_SHIFT);
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Saturating 0..DATA_W bit counter; 'last' flags the pulse that completes a byte.
module spi_bit_counter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/spi_mem_sequencer.sv
// Clock-domain sequencer for a mode-0 SPI slave memory: decodes the command byte
// and runs single or burst read/write transfers with an auto-incrementing address.
module spi_mem_sequencer
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BURST_EN = 1,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              sclk_pos,
    input  logic              sclk_neg,
    input  logic [DATA_W-1:0] sr_pout,
    output logic              sr_shift_en,
    output logic              sr_load,
    output logic [ADDR_W-1:0] addr,
    output logic              dm_we,
    output logic              miso_oe,
    output logic              busy,
    output logic              abort
);

    localparam int               CNT_W     = $clog2(DATA_W + 1);
    localparam logic [1:0]       WAIT_LAST = 2'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        wait_q, wait_d;
    logic              sr_load_q, sr_load_d;
    logic              dm_we_q, dm_we_d;
    logic              miso_oe_q, miso_oe_d;
    logic              busy_q, busy_d;
    logic              abort_q, abort_d;

    logic              cnt_en_s;
    logic              cnt_clr_s;
    logic              cnt_last_s;
    logic [CNT_W-1:0]  cnt_s;

    spi_bit_counter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .cnt   (cnt_s),
        .last  (cnt_last_s)
    );

    // Next-state, address and registered-output decode.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        abort_d = 1'b0;
        if (cs) begin
            // Deselect wins over everything, including a byte-completing SCLK edge.
            state_d = ST_IDLE;
            abort_d = (is_count_state(state_q) && (cnt_s != {CNT_W{1'b0}})) ||
                      (state_q inside {ST_DECODE, ST_RD_FETCH, ST_RD_LOAD});
            if ((state_q == ST_RD_NEXT) || (state_q == ST_WR_COMMIT)) begin
                addr_d = addr_q + ADDR_ONE;
            end else begin
                addr_d = addr_q;
            end
        end else begin
            case (state_q)
                ST_IDLE:     state_d = ST_CMD;
                ST_CMD:      state_d = cnt_last_s ? ST_DECODE : ST_CMD;
                ST_DECODE: begin
                    addr_d  = sr_pout[DATA_W-1:1];
                    state_d = (sr_pout[RW_BIT] == CMD_READ) ? ST_RD_FETCH : ST_WR_SHIFT;
                end
                ST_RD_FETCH: state_d = (wait_q == WAIT_LAST) ? ST_RD_LOAD : ST_RD_FETCH;
                ST_RD_LOAD:  state_d = ST_RD_SHIFT;
                ST_RD_SHIFT: state_d = cnt_last_s ? ST_RD_NEXT : ST_RD_SHIFT;
                ST_RD_NEXT: begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = (BURST_EN != 0) ? ST_RD_FETCH : ST_DONE;
                end
                ST_WR_SHIFT: state_d = cnt_last_s ? ST_WR_COMMIT : ST_WR_SHIFT;
                ST_WR_COMMIT: begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = (BURST_EN != 0) ? ST_WR_SHIFT : ST_DONE;
                end
                ST_DONE:     state_d = ST_DONE;
                default:     state_d = ST_IDLE;
            endcase
        end

        wait_d    = ((state_q == ST_RD_FETCH) && (state_d == ST_RD_FETCH)) ? (wait_q + 2'd1) : 2'd0;
        sr_load_d = (state_d == ST_RD_LOAD);
        dm_we_d   = (state_d == ST_WR_COMMIT);
        miso_oe_d = (state_d == ST_RD_SHIFT);
        busy_d    = (state_d != ST_IDLE);
        cnt_clr_s = (state_d != state_q);
        cnt_en_s  = !cs && sclk_pos && is_count_state(state_q);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= {ADDR_W{1'b0}};
            wait_q    <= 2'd0;
            sr_load_q <= 1'b0;
            dm_we_q   <= 1'b0;
            miso_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wait_q    <= wait_d;
            sr_load_q <= sr_load_d;
            dm_we_q   <= dm_we_d;
            miso_oe_q <= miso_oe_d;
            busy_q    <= busy_d;
            abort_q   <= abort_d;
        end
    end

    // Reads shift out on the falling edge; command and write data sample on the rising edge.
    assign sr_shift_en = !cs && ((sclk_pos && ((state_q == ST_CMD) || (state_q == ST_WR_SHIFT))) ||
                                 (sclk_neg && (state_q == ST_RD_SHIFT)));
    assign sr_load = sr_load_q;
    assign addr    = addr_q;
    assign dm_we   = dm_we_q;
    assign miso_oe = miso_oe_q;
    assign busy    = busy_q;
    assign abort   = abort_q;

endmodule
